ofifo_align: RTL and testbench



---
 rtl/ofifo_align.sv | 93 +++++++++
 tb/tb_ofifo_align.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_align.sv
// ofifo_align: per-column circular FIFOs that absorb skewed MAC column
// writes and release one aligned row of psums per accepted read.
module ofifo_align #(
   parameter int unsigned col     = 8,
   parameter int unsigned bw_psum = 11,
   parameter int unsigned depth   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col-1:0]           wr,
   input  logic [col*bw_psum-1:0]   in,
   input  logic                     rd,
   output logic [col*bw_psum-1:0]   out,
   output logic                     o_rd_vld,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_err
);

   localparam int unsigned AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [bw_psum-1:0]     mem  [col][depth];
   logic [AW:0]            wptr [col];
   logic [AW:0]            rptr [col];
   logic [col-1:0]         full_c;
   logic [col-1:0]         empty_c;
   logic [col-1:0]         wr_ok;
   logic [col*bw_psum-1:0] head;
   logic                   rd_acc;

   // Per-column status flags, accepted writes and head word, all from pre-edge state
   always_comb begin
      full_c  = '0;
      empty_c = '0;
      wr_ok   = '0;
      head    = '0;
      for (int unsigned i = 0; i < col; i++) begin
         empty_c[i] = (wptr[i] == rptr[i]);
         full_c[i]  = (wptr[i][AW-1:0] == rptr[i][AW-1:0]) &&
                      (wptr[i][AW] != rptr[i][AW]);
         wr_ok[i]   = wr[i] & ~full_c[i];
         head[i*bw_psum +: bw_psum] = mem[i][rptr[i][AW-1:0]];
      end
   end

   assign o_valid = &(~empty_c);
   assign o_full  = |full_c;
   assign rd_acc  = rd & o_valid;

   // Column storage; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < col; i++) begin
            if (wr_ok[i])
               mem[i][wptr[i][AW-1:0]] <= in[i*bw_psum +: bw_psum];
         end
      end
   end

   // Write pointers advance per column; read pointers advance together on an accepted read
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < col; i++) begin
            wptr[i] <= '0;
            rptr[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < col; i++) begin
            if (wr_ok[i])
               wptr[i] <= wptr[i] + PTR_ONE;
            if (rd_acc)
               rptr[i] <= rptr[i] + PTR_ONE;
         end
      end
   end

   // Registered row output, read-valid strobe and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         out      <= '0;
         o_rd_vld <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         o_rd_vld <= rd_acc;
         if (rd_acc)
            out <= head;
         if (|(wr & full_c))
            o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo_align.sv
// tb_ofifo_align: directed table plus hand-written corner sequences for ofifo_align.
module tb_ofifo_align;

   localparam int COL   = 8;
   localparam int BW    = 11;
   localparam int DEPTH = 16;
   localparam int W     = COL * BW;

   logic           clk;
   logic           reset;
   logic [COL-1:0] wr;
   logic [W-1:0]   in_d;
   logic           rd;
   logic [W-1:0]   out_d;
   logic           o_rd_vld;
   logic           o_valid;
   logic           o_full;
   logic           o_err;

   int errors = 0;
   int checks = 0;

   ofifo_align #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .in       (in_d),
      .rd       (rd),
      .out      (out_d),
      .o_rd_vld (o_rd_vld),
      .o_valid  (o_valid),
      .o_full   (o_full),
      .o_err    (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic           rst;
      logic [COL-1:0] wr;
      logic [W-1:0]   din;
      logic           rd;
      logic           e_valid;
      logic           e_full;
      logic           e_err;
      logic           e_rdvld;
      logic [W-1:0]   e_out;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] mk_row(input int mul, input int off, input int n);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < COL; i++)
         r[i*BW +: BW] = BW'(i*mul + off + n);
      return r;
   endfunction

   function automatic logic [W-1:0] put(input int k, input int v);
      logic [W-1:0] r;
      r = '0;
      r[k*BW +: BW] = BW'(v);
      return r;
   endfunction

   function automatic vec_t mkv(input logic rst, input logic [COL-1:0] w, input logic [W-1:0] d,
                                input logic r, input logic ev, input logic ef, input logic ee,
                                input logic erv, input logic [W-1:0] eo);
      vec_t v;
      v.rst = rst; v.wr = w; v.din = d; v.rd = r;
      v.e_valid = ev; v.e_full = ef; v.e_err = ee; v.e_rdvld = erv; v.e_out = eo;
      return v;
   endfunction

   initial begin
      logic [W-1:0] skew_row;
      logic [W-1:0] exp_row;
      int rows;
      int full_seen;
      int n;

      reset = 1'b1; wr = '0; in_d = '0; rd = 1'b0;

      // ---------------- table: reset, idle, empty read, skewed fill, one read
      skew_row = mk_row(16, 1, 0);
      tbl[0]  = mkv(1'b1, '0, '0, 1'b0, 0, 0, 0, 0, '0);
      tbl[1]  = mkv(1'b0, '0, '0, 1'b0, 0, 0, 0, 0, '0);
      tbl[2]  = mkv(1'b0, '0, '0, 1'b1, 0, 0, 0, 0, '0);
      for (int k = 0; k < COL; k++)
         tbl[3+k] = mkv(1'b0, COL'(1) << k, put(k, 16*k + 1), 1'b0,
                        (k == COL-1), 0, 0, 0, '0);
      tbl[11] = mkv(1'b0, '0, '0, 1'b1, 0, 0, 0, 1, skew_row);
      tbl[12] = mkv(1'b0, '0, '0, 1'b0, 0, 0, 0, 0, skew_row);

      for (int v = 0; v < 13; v++) begin
         reset = tbl[v].rst; wr = tbl[v].wr; in_d = tbl[v].din; rd = tbl[v].rd;
         tick();
         chk($sformatf("tbl%0d_valid", v), o_valid,  tbl[v].e_valid);
         chk($sformatf("tbl%0d_full",  v), o_full,   tbl[v].e_full);
         chk($sformatf("tbl%0d_err",   v), o_err,    tbl[v].e_err);
         chk($sformatf("tbl%0d_rdvld", v), o_rd_vld, tbl[v].e_rdvld);
         chk($sformatf("tbl%0d_out",   v), out_d,    tbl[v].e_out);
      end
      reset = 1'b0; wr = '0; in_d = '0; rd = 1'b0;

      // ---------------- continuous skewed stream with rd held high
      rows = 0; full_seen = 0;
      for (int t = 0; t < 200 && rows < 40; t++) begin
         wr = '0; in_d = '0;
         for (int i = 0; i < COL; i++) begin
            n = t - i;
            if (n >= 0 && n < 40) begin
               wr[i] = 1'b1;
               in_d[i*BW +: BW] = BW'(i*100 + n);
            end
         end
         rd = 1'b1;
         tick();
         if (o_full) full_seen = 1;
         if (o_rd_vld) begin
            chk($sformatf("stream_row%0d", rows), out_d, mk_row(100, 0, rows));
            rows++;
         end
      end
      wr = '0; in_d = '0; rd = 1'b0;
      chk("stream_count", W'(rows), W'(40));
      chk("stream_full_seen", W'(full_seen), '0);
      chk("stream_err", o_err, 1'b0);
      tick();
      chk("stream_empty_valid", o_valid, 1'b0);

      // ---------------- overflow on column 3
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k <= DEPTH; k++) begin
         wr = COL'(8); in_d = put(3, k);
         tick();
         if (k == DEPTH-2) chk("ovf_full_before", o_full, 1'b0);
         if (k == DEPTH-1) begin
            chk("ovf_full_at16", o_full, 1'b1);
            chk("ovf_err_at16", o_err, 1'b0);
         end
         if (k == DEPTH) begin
            chk("ovf_full_at17", o_full, 1'b1);
            chk("ovf_err_at17", o_err, 1'b1);
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         wr = 8'hF7; in_d = mk_row(100, 0, k);
         tick();
      end
      wr = '0; in_d = '0;
      chk("ovf_valid_filled", o_valid, 1'b1);
      rows = 0; rd = 1'b1;
      for (int t = 0; t < DEPTH + 1; t++) begin
         tick();
         if (o_rd_vld) begin
            exp_row = mk_row(100, 0, rows);
            exp_row[3*BW +: BW] = BW'(rows);
            chk($sformatf("ovf_row%0d", rows), out_d, exp_row);
            rows++;
         end
      end
      rd = 1'b0;
      chk("ovf_count", W'(rows), W'(16));
      chk("ovf_valid_drained", o_valid, 1'b0);
      chk("ovf_full_drained", o_full, 1'b0);
      chk("ovf_err_sticky", o_err, 1'b1);

      // ---------------- all full, simultaneous rd and wr
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_err_clear", o_err, 1'b0);
      for (int k = 0; k < DEPTH; k++) begin
         wr = '1; in_d = mk_row(100, 0, k);
         tick();
      end
      chk("fs_full", o_full, 1'b1);
      chk("fs_valid", o_valid, 1'b1);
      chk("fs_err_pre", o_err, 1'b0);
      wr = '1; in_d = '1; rd = 1'b1;
      tick();
      wr = '0; in_d = '0; rd = 1'b0;
      chk("fs_rdvld", o_rd_vld, 1'b1);
      chk("fs_out", out_d, mk_row(100, 0, 0));
      chk("fs_err", o_err, 1'b1);
      chk("fs_full_after", o_full, 1'b0);
      rows = 0; rd = 1'b1;
      for (int t = 0; t < DEPTH; t++) begin
         tick();
         if (o_rd_vld) begin
            chk($sformatf("fs_row%0d", rows + 1), out_d, mk_row(100, 0, rows + 1));
            rows++;
         end
      end
      rd = 1'b0;
      chk("fs_count", W'(rows), W'(15));
      chk("fs_valid_drained", o_valid, 1'b0);

      // ---------------- mid-stream reset with 5 rows buffered
      for (int k = 0; k < 6; k++) begin
         wr = '1; in_d = mk_row(100, 1000, k);
         tick();
      end
      wr = '0; in_d = '0; rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("mr_pre_out", out_d, mk_row(100, 1000, 0));
      chk("mr_pre_err", o_err, 1'b1);
      chk("mr_pre_valid", o_valid, 1'b1);
      reset = 1'b1; wr = '1; in_d = mk_row(1, 1500, 0); rd = 1'b1;
      tick();
      reset = 1'b0; wr = '0; in_d = '0; rd = 1'b0;
      chk("mr_valid", o_valid, 1'b0);
      chk("mr_err", o_err, 1'b0);
      chk("mr_out", out_d, '0);
      chk("mr_rdvld", o_rd_vld, 1'b0);
      chk("mr_full", o_full, 1'b0);
      wr = '1; in_d = mk_row(3, 1600, 0);
      tick();
      wr = '0; in_d = '0;
      chk("mr_fill_valid", o_valid, 1'b1);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("mr_read_out", out_d, mk_row(3, 1600, 0));
      chk("mr_read_rdvld", o_rd_vld, 1'b1);
      chk("mr_read_valid", o_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
